// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream input and instruction-memory write port of the loader
interface imem_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time instruction memory writer: header, LE words, XOR checksum
module imem_loader #(
    parameter int n = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         busy,
    output logic         done,
    output logic         err
);
    localparam int IDX_W = $clog2(n + 2);
    localparam logic [15:0] MAX_CNT = 16'(n + 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] HDR0 = 3'd1;
    localparam logic [2:0] HDR1 = 3'd2;
    localparam logic [2:0] WORD = 3'd3;
    localparam logic [2:0] CSUM = 3'd4;
    localparam logic [2:0] DONE = 3'd5;
    localparam logic [2:0] ERR  = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [7:0]       cnt_lo_q, cnt_lo_d;
    logic [IDX_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] word_idx_q, word_idx_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [23:0]      lanes_q, lanes_d;
    logic [7:0]       acc_q, acc_d;
    logic             wr_en_q, wr_en_d;
    logic [31:0]      wr_addr_q, wr_addr_d;
    logic [31:0]      wr_data_q, wr_data_d;

    logic             xfer;
    logic [15:0]      count_rx;
    logic [IDX_W-1:0] word_idx_inc;

    // Ready is a pure state decode so the source never sees a path from its own valid.
    assign busy = (state_q == HDR0) || (state_q == HDR1) ||
                  (state_q == WORD) || (state_q == CSUM);
    assign done = (state_q == DONE);
    assign err  = (state_q == ERR);

    assign bus.byte_ready = busy;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;

    assign xfer         = bus.byte_valid && busy;
    assign count_rx     = {bus.byte_data, cnt_lo_q};
    assign word_idx_inc = word_idx_q + IDX_W'(1);

    always_comb begin
        state_d    = state_q;
        cnt_lo_d   = cnt_lo_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        lanes_d    = lanes_q;
        acc_d      = acc_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d    = HDR0;
                    acc_d      = 8'd0;
                    word_idx_d = '0;
                    byte_idx_d = 2'd0;
                end
            end
            HDR0: begin
                if (xfer) begin
                    cnt_lo_d = bus.byte_data;
                    acc_d    = acc_q ^ bus.byte_data;
                    state_d  = HDR1;
                end
            end
            HDR1: begin
                if (xfer) begin
                    acc_d   = acc_q ^ bus.byte_data;
                    count_d = count_rx[IDX_W-1:0];
                    if (count_rx > MAX_CNT) begin
                        state_d = ERR;
                    end else if (count_rx == 16'd0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = WORD;
                    end
                end
            end
            WORD: begin
                if (xfer) begin
                    acc_d      = acc_q ^ bus.byte_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: lanes_d[7:0]   = bus.byte_data;
                        2'd1: lanes_d[15:8]  = bus.byte_data;
                        2'd2: lanes_d[23:16] = bus.byte_data;
                        default: begin
                            wr_en_d    = 1'b1;
                            wr_data_d  = {bus.byte_data, lanes_q};
                            wr_addr_d  = {{(30 - IDX_W){1'b0}}, word_idx_q, 2'b00};
                            word_idx_d = word_idx_inc;
                            if (word_idx_inc == count_q) begin
                                state_d = CSUM;
                            end
                        end
                    endcase
                end
            end
            CSUM: begin
                if (xfer) begin
                    state_d = (bus.byte_data == acc_q) ? DONE : ERR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_lo_q   <= 8'd0;
            count_q    <= '0;
            word_idx_q <= '0;
            byte_idx_q <= 2'd0;
            lanes_q    <= 24'd0;
            acc_q      <= 8'd0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 32'd0;
            wr_data_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_lo_q   <= cnt_lo_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            lanes_q    <= lanes_d;
            acc_q      <= acc_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory. It accepts a byte stream over a valid/ready handshake, checks a word-count header, assembles little-endian 32-bit instructions, and issues one write per word on the instruction memory write port at the same byte addresses the fetch stage later presents as `pc`. A trailing XOR checksum validates the image, and the result is reported on `done`/`err`.

## Interface
Parameters:
- `n`, 20: highest word index of the instruction memory; the memory holds n+1 words, so the maximum image is n+1 words.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle launch request; honoured only in IDLE, DONE, ERR.
- `byte_valid`  in  1  a source byte is present.
- `byte_data`  in  8  the source byte.
- `byte_ready`  out  1  loader accepts a byte; a transfer occurs when `byte_valid` and `byte_ready` are both high.
- `wr_en`  out  1  one-cycle write strobe to the instruction memory.
- `wr_addr`  out  32  byte address, equal to word index × 4.
- `wr_data`  out  32  instruction word.
- `busy`  out  1  a load is in progress (HDR0 through CSUM).
- `done`  out  1  image loaded and checksum matched; held until the next `start` or `rst`.
- `err`  out  1  count overflow or checksum mismatch; held until the next `start` or `rst`.

## Operation
- **Stream format.** cnt_lo, cnt_hi (16-bit word count, little-endian), then cnt×4 data bytes (each word LSB first), then 1 checksum byte. The checksum is the XOR of every header and data byte.
- **States.** IDLE, HDR0, HDR1, WORD, CSUM, DONE, ERR.
- **IDLE.** On `start`, go to HDR0. Clear the checksum accumulator, the word index and the byte index. Clear `done` and `err`. DONE and ERR handle `start` the same way.
- **HDR0.** On a transfer, latch cnt_lo and go to HDR1.
- **HDR1.** On a transfer, latch cnt_hi and form the count.
  - If count > n+1, go to ERR.
  - If count == 0, go to CSUM.
  - Otherwise go to WORD.
- **WORD.**
  - A 2-bit byte index selects the byte lane (lane k ← byte k).
  - On the 4th transfer, register `wr_data` and `wr_addr` = word_idx×4, pulse `wr_en`, increment word_idx and reset the byte index.
  - After the last word, go to CSUM.
- **CSUM.** On a transfer, compare the byte with the accumulator. Match goes to DONE; mismatch goes to ERR.
- **No rollback.** Writes already issued are never rolled back. On ERR, the memory contents are undefined for the user.
- **`byte_ready`.** A decode of the state only: high in HDR0, HDR1, WORD, CSUM; low elsewhere. It has no combinational path from `byte_valid`.
- **Ignored inputs.**
  - `start` while `busy` is ignored.
  - `byte_valid` in IDLE, DONE or ERR is ignored; no byte is consumed.
- **Accumulator.** Updated by XOR on every accepted header or data byte, not on the checksum byte.

## Timing
- **Reset values:** `byte_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `err`=0. State = IDLE; all counters = 0.
- **Reset mid-load.** `rst` mid-load returns to IDLE on the next edge, and no further `wr_en` is issued.
- **Start.** `start` sampled at edge t gives `busy`=1 and `byte_ready`=1 from t+1.
- **Write latency.** `wr_en` is high for exactly the one cycle after the edge that accepts a word's 4th byte. `wr_addr`/`wr_data` are valid in that cycle and hold their values afterwards.
- **Throughput.** One byte per cycle with no bubbles. Back-to-back words give a `wr_en` every 4 cycles.
- **Source stalls.** Gaps in `byte_valid` stall progress without loss.
- **`byte_data` sampling.** Sampled only on transfer cycles.
- **Completion.** `done` or `err` rises, and `busy` falls, in the cycle after the deciding transfer (the checksum byte, or cnt_hi on overflow). `byte_ready` is low from that same cycle.
- **Exclusivity.** `done` and `err` are never both high.
- **Address width.** word_idx is ⌈log2(n+2)⌉ bits. `wr_addr` is zero-extended to 32 bits; the maximum address is n×4 (80 for n=20).

## Test plan
- **Two-word load.** `start`; stream 02 00 93 00 50 00 13 01 10 00 C3 with `byte_valid` held high.
  - Expect `wr_en` at addr 0 with data 0x00500093, then at addr 4 with data 0x00100113, 4 cycles apart.
  - Expect `done`=1, `err`=0, `busy`=0.
- **Zero-length image.** Stream 00 00 00.
  - Expect no `wr_en`, `done`=1 one cycle after the 3rd byte.
- **Count overflow** (n=20). Stream 16 00 (count 22).
  - Expect `err`=1 and `byte_ready`=0 the cycle after cnt_hi; no `wr_en`; further bytes not consumed.
- **Bad checksum.** Stream 01 00 93 00 50 00 00.
  - Expect one `wr_en` (addr 0, data 0x00500093), then `err`=1, `done`=0.
- **Backpressure gaps.** Repeat the two-word load with `byte_valid` low on every other cycle.
  - Expect identical writes and `done`, with `wr_en` spaced 8 cycles apart.
  - Expect `start` pulses issued mid-load to be ignored.
- **Reset mid-load.** Assert `rst` after the 6th byte of the two-word load.
  - Expect all outputs at reset values and no 2nd `wr_en`.
  - A subsequent `start` followed by the full stream gives `done`=1.
